// File: rtl/crg_pkg.sv
// Shared types for the clock/reset generator slice: gate enable sequencer state
// encoding, which is also the value presented on clk_gate_ctrl.state_o.
package crg_pkg;

  localparam logic [1:0] OFF_ENC   = 2'd0;
  localparam logic [1:0] WAKE_ENC  = 2'd1;
  localparam logic [1:0] ON_ENC    = 2'd2;
  localparam logic [1:0] DRAIN_ENC = 2'd3;

  typedef enum logic [1:0] {
    OFF   = OFF_ENC,
    WAKE  = WAKE_ENC,
    ON    = ON_ENC,
    DRAIN = DRAIN_ENC
  } clk_gate_ctrl_state_e;

endpackage

// File: rtl/clk_gate_ctrl.sv
// Enable sequencer feeding a clock gate cell: opens on request/activity, acks after
// WAKE_DLY cycles, closes after IDLE_CYCLES consecutive idle samples.
// Optional macro CLK_GATE_CTRL_FORCE_EN adds test_en_i to force the gate open.
module clk_gate_ctrl
  import crg_pkg::*;
#(
  parameter int WAKE_DLY    = 2,
  parameter int IDLE_CYCLES = 16,
  parameter int CNT_W       = $clog2((WAKE_DLY > IDLE_CYCLES) ? WAKE_DLY : IDLE_CYCLES) + 1
) (
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic       req_i,
  input  logic       idle_i,
`ifdef CLK_GATE_CTRL_FORCE_EN
  input  logic       test_en_i,
`endif
  output logic       en_o,
  output logic       ack_o,
  output logic [1:0] state_o
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_DLY);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

  clk_gate_ctrl_state_e state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 en_q, ack_q;
  logic                 qual_idle;
  logic                 hold_open;

`ifdef CLK_GATE_CTRL_FORCE_EN
  assign hold_open = test_en_i;
`else
  assign hold_open = 1'b0;
`endif

  assign qual_idle = ~req_i & idle_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      OFF: begin
        if (req_i || !idle_i) begin
          state_d = WAKE;
          cnt_d   = CNT_ONE;
        end
      end
      WAKE: begin
        if (cnt_q >= WAKE_LAST) begin
          state_d = ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ON: begin
        if (qual_idle) begin
          state_d = DRAIN;
          cnt_d   = CNT_ONE;
        end
      end
      DRAIN: begin
        // Any busy/request sample aborts the drain, even on the final idle count
        if (!qual_idle) begin
          state_d = ON;
          cnt_d   = '0;
        end else if (cnt_q >= IDLE_LAST) begin
          if (!hold_open) begin
            state_d = OFF;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are flopped from the next state so they change on the same edge as state_q
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= OFF;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= (state_d != OFF);
      ack_q   <= (state_d == ON) || (state_d == DRAIN);
    end
  end

`ifdef CLK_GATE_CTRL_FORCE_EN
  assign en_o = en_q | test_en_i;
`else
  assign en_o = en_q;
`endif
  assign ack_o   = ack_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl: directed scenarios plus random req/idle traffic
// checked against a behavioural model of the gate's on/ack/idle-run rules.
module tb_clk_gate_ctrl;

  localparam int WAKE_DLY    = 2;
  localparam int IDLE_CYCLES = 16;

  logic       clk_i = 1'b0;
  logic       arst_ni = 1'b0;
  logic       req_i = 1'b0;
  logic       idle_i = 1'b1;
`ifdef CLK_GATE_CTRL_FORCE_EN
  logic       test_en_i = 1'b0;
`endif
  logic       en_o, ack_o;
  logic [1:0] state_o;

  clk_gate_ctrl #(.WAKE_DLY(WAKE_DLY), .IDLE_CYCLES(IDLE_CYCLES)) dut (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .req_i   (req_i),
    .idle_i  (idle_i),
`ifdef CLK_GATE_CTRL_FORCE_EN
    .test_en_i(test_en_i),
`endif
    .en_o    (en_o),
    .ack_o   (ack_o),
    .state_o (state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       en;
    logic       ack;
    logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model: gate on/off, acknowledged or not, wake countdown, idle run length
  bit m_on, m_acked;
  int m_wake_left, m_idle_run;

  function automatic void model_reset();
    m_on = 0; m_acked = 0; m_wake_left = 0; m_idle_run = 0;
  endfunction

  function automatic void model_step(input logic r, input logic i, input logic force_en);
    if (!m_on) begin
      if (r || !i) begin
        m_on = 1; m_wake_left = WAKE_DLY;
      end
    end else if (!m_acked) begin
      m_wake_left--;
      if (m_wake_left == 0) m_acked = 1;
    end else if (!r && i) begin
      if (m_idle_run + 1 >= IDLE_CYCLES && !force_en) begin
        m_on = 0; m_acked = 0; m_idle_run = 0;
      end else if (m_idle_run + 1 < IDLE_CYCLES) begin
        m_idle_run++;
      end
    end else begin
      m_idle_run = 0;
    end
  endfunction

  function automatic exp_t model_out(input logic force_en);
    exp_t e;
    e.en  = m_on | force_en;
    e.ack = m_acked;
    if (!m_on)              e.st = 2'd0;
    else if (!m_acked)      e.st = 2'd1;
    else if (m_idle_run==0) e.st = 2'd2;
    else                    e.st = 2'd3;
    return e;
  endfunction

  function automatic logic cur_force();
`ifdef CLK_GATE_CTRL_FORCE_EN
    return test_en_i;
`else
    return 1'b0;
`endif
  endfunction

  task automatic cyc(input logic r, input logic i);
    req_i = r; idle_i = i;
    @(posedge clk_i);
    if (!arst_ni) model_reset();
    else model_step(r, i, cur_force());
    exp_q.push_back(model_out(cur_force()));
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expected response per cycle, sampled on the falling edge
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("en_o",    {3'b0, en_o},    {3'b0, e.en});
      check("ack_o",   {3'b0, ack_o},   {3'b0, e.ack});
      check("state_o", {2'b0, state_o}, {2'b0, e.st});
    end
  end

  initial begin
    model_reset();
    // Reset held with a pending request
    repeat (3) cyc(1'b1, 1'b1);
    arst_ni = 1'b1;
    repeat (4) cyc(1'b1, 1'b1);
    // Release request; drain all the way to OFF
    repeat (20) cyc(1'b0, 1'b1);
    // Wake on downstream activity, then drain
    cyc(1'b0, 1'b0);
    repeat (22) cyc(1'b0, 1'b1);
    // Interrupted drain after 10 idle samples
    repeat (3) cyc(1'b1, 1'b1);
    repeat (10) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    repeat (17) cyc(1'b0, 1'b1);
    // Re-request coincides with the final idle sample
    repeat (3) cyc(1'b1, 1'b1);
    repeat (15) cyc(1'b0, 1'b1);
    repeat (3) cyc(1'b1, 1'b1);
    repeat (17) cyc(1'b0, 1'b1);
    // Request dropped during wake; wake still completes
    cyc(1'b1, 1'b1);
    repeat (20) cyc(1'b0, 1'b1);
    // Asynchronous reset between edges, mid-drain
    repeat (3) cyc(1'b1, 1'b1);
    repeat (5) cyc(1'b0, 1'b1);
    #6 arst_ni = 1'b0;
    #1 check("async_rst", {2'b0, en_o, ack_o}, 4'b0000);
    model_reset();
    repeat (2) cyc(1'b0, 1'b1);
    arst_ni = 1'b1;
`ifdef CLK_GATE_CTRL_FORCE_EN
    repeat (3) cyc(1'b1, 1'b1);
    test_en_i = 1'b1;
    repeat (100) cyc(1'b0, 1'b1);
    test_en_i = 1'b0;
    repeat (20) cyc(1'b0, 1'b1);
`endif
    // Random traffic: sticky request, mostly-idle downstream
    begin
      logic r;
      r = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 24) == 0) r = ~r;
        cyc(r, ($urandom_range(0, 15) != 0));
      end
    end
    // Let the monitor drain the scoreboard, bounded
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk_i);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
